// File: rtl/spi_reg_if.sv
// SPI mode-0 slave that turns an address byte plus a burst of data bytes into
// single-cycle register-write strobes with an auto-incrementing pointer.
module spi_reg_if #(
    parameter int unsigned NUM_REGS    = 31,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       we,
    output logic [7:0] addr,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       wr_err
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic [SYNC_STAGES:0]   flush_q;
    logic                   armed_q, armed_d;
    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             shift_q, shift_d;
    logic [7:0]             ptr_q, ptr_d;
    logic [7:0]             addr_q, addr_d;
    logic [7:0]             data_q, data_d;
    logic                   we_q, we_d;
    logic                   err_q, err_d;

    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, cs_fall, cs_rise;
    logic [7:0] rx_byte;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign rx_byte   = {shift_q, mosi_s};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
            flush_q     <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q   <= 1'b0;
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
            ptr_q     <= 8'd0;
            addr_q    <= 8'd0;
            data_q    <= 8'd0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            armed_q   <= armed_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        // Arm only once the synchronizer carries real post-reset pin values and
        // cs_n is seen high, so a cs_n held low across reset starts no frame.
        armed_d   = armed_q | (flush_q[SYNC_STAGES] & cs_s);
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (cs_fall && armed_q) begin
                    state_d   = StAddr;
                    bit_cnt_d = 3'd0;
                end
            end
            StAddr, StData: begin
                if (sclk_rise) begin
                    shift_d   = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == StAddr) begin
                            ptr_d   = rx_byte;
                            state_d = StData;
                        end else begin
                            if (32'(ptr_q) < NUM_REGS) begin
                                we_d   = 1'b1;
                                addr_d = ptr_q;
                                data_d = rx_byte;
                            end else begin
                                err_d = 1'b1;
                            end
                            ptr_d = ptr_q + 8'd1;
                        end
                    end
                end
                // A byte completing in this same cycle is still emitted above.
                if (cs_rise) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign we       = we_q;
    assign wr_err   = err_q;
    assign addr     = addr_q;
    assign data_out = data_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: doc/spi_reg_if.md
SPI_REG_IF -- requirements
Module: spi_reg_if

Interface
REQ-001 The module SHALL have parameter NUM_REGS, default 31, meaning the number of valid register addresses (0 .. NUM_REGS-1).
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, meaning the flip-flop depth of each input synchronizer (minimum 2).
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port sclk, input, 1 bit: SPI serial clock, asynchronous to clk.
REQ-006 The module SHALL have port cs_n, input, 1 bit: SPI chip select, active low, asynchronous to clk.
REQ-007 The module SHALL have port mosi, input, 1 bit: SPI serial data in.
REQ-008 The module SHALL have port we, output, 1 bit: register-write strobe to the register map.
REQ-009 The module SHALL have port addr, output, 8 bits: register-write address.
REQ-010 The module SHALL have port data_out, output, 8 bits: register-write data byte.
REQ-011 The module SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-012 The module SHALL have port wr_err, output, 1 bit: one-cycle pulse when a write to an out-of-range address is dropped.

Function
REQ-013 sclk, cs_n and mosi SHALL each pass through a SYNC_STAGES-deep synchronizer before any use; the synchronizers for sclk and cs_n SHALL reset to 1, and the synchronizer for mosi SHALL reset to 0.
REQ-014 The SPI protocol SHALL be mode 0: mosi is sampled on a synchronized sclk rising edge, MSB first; the legal sclk frequency is at most clk/8.
REQ-015 The FSM SHALL have three states, IDLE, ADDR and DATA; the reset state SHALL be IDLE.
REQ-016 The FSM SHALL go from IDLE to ADDR on a synchronized cs_n falling edge, clearing the bit counter to 0.
REQ-017 In ADDR, after 8 bits are received, the received byte SHALL load the internal address pointer and the FSM SHALL go to DATA; no write occurs.
REQ-018 In DATA, after each 8 bits are received, the byte SHALL be emitted as a write at the current pointer, and the pointer SHALL then increment modulo 256.
REQ-019 A write SHALL present addr and data_out stable in the same cycle that we=1; we SHALL be high for exactly one clk cycle per byte.
REQ-020 Write latency SHALL be SYNC_STAGES+2 clk cycles (±1) from the 8th sclk rising edge at the pin to we=1.
REQ-021 addr and data_out SHALL hold their last values after we falls, until the next write.
REQ-022 For a DATA byte whose pointer is >= NUM_REGS, we SHALL stay 0, wr_err SHALL pulse for one cycle in its place, and the pointer SHALL still increment.
REQ-023 A synchronized cs_n rising edge in any state SHALL return the FSM to IDLE, discard any partial byte (1-7 bits), and produce no write.
REQ-024 sclk edges while in IDLE SHALL be ignored.
REQ-025 If cs_n rises in the same cycle that the 8th bit completes, the byte SHALL be emitted (or flagged as in REQ-022) before the FSM enters IDLE.
REQ-026 busy SHALL be 1 in ADDR and DATA, and 0 in IDLE.
REQ-027 The address byte SHALL NOT be range-checked; checking SHALL occur per data byte.

Reset
REQ-028 rst=0 SHALL immediately force: state IDLE, we=0, wr_err=0, busy=0, addr=0x00, data_out=0x00, pointer=0x00, bit counter=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no write.
REQ-030 After rst rises, a frame SHALL be accepted only on a fresh cs_n falling edge; if cs_n is already low when reset is released, the module SHALL stay in IDLE until cs_n goes high and then low again.

Verification
REQ-031 Frame 0x00,0xAA -> exactly one we pulse with addr=0x00, data_out=0xAA; busy falls after cs_n rises.
REQ-032 Burst frame 0x04,0xC7,0x71,0x1C -> three pulses: (0x04,0xC7), (0x05,0x71), (0x06,0x1C); downstream gain_2 reads 0x1C71C7.
REQ-033 Burst frame 0x1D,0xFF,0xFF,0xFF with NUM_REGS=31 -> writes to 0x1D and 0x1E, then a wr_err pulse for 0x1F with no we for that byte.
REQ-034 Frame 0x02 followed by 5 data bits, then cs_n rises -> no we pulse; the next frame 0x03,0x55 writes (0x03,0x55) correctly.
REQ-035 rst driven low during the 4th bit of a data byte -> all outputs 0 immediately and no write; after release, a full frame 0x10,0x3F writes (0x10,0x3F).
REQ-036 sclk toggling with cs_n high, and sclk at exactly clk/8 -> no spurious writes, and each byte is received correctly.
